// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_pkg;

    localparam logic [5:0] CMD_GO_IDLE  = 6'd0;
    localparam logic [5:0] CMD_SEND_IF  = 6'd8;
    localparam logic [5:0] CMD_SET_BLEN = 6'd16;
    localparam logic [5:0] CMD_READ     = 6'd17;
    localparam logic [5:0] CMD_WRITE    = 6'd24;
    localparam logic [5:0] ACMD_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP      = 6'd55;
    localparam logic [5:0] CMD_READ_OCR = 6'd58;

    localparam logic [7:0] TOK_START   = 8'hFE;
    localparam logic [7:0] TOK_DATA_OK = 8'h05;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] R1_PARAM   = 8'h40;

    localparam logic [31:0] OCR_VAL = 32'hC0FF8000;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_NCR, ST_RESP,
        ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC,
        ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_WR_BUSY
    } sd_state_e;

    // Block transfer in progress, from the token byte to the last CRC/busy byte.
    function automatic logic is_xfer(sd_state_e s);
        return s inside {ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC,
                         ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_WR_BUSY};
    endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 target byte engine: synchronizers, edge detect, RX/TX shift
// registers. tx_byte is loaded at each byte boundary (falling edge after bit 8).
module sd_spi_shifter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic [7:0] tx_byte,
    output logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       first_fall,
    output logic       cs_on
);
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;   // {cs_n, mosi, sclk}
    logic       sclk_prev_q, sclk_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic       miso_q, miso_d;
    logic       byte_done_q, byte_done_d, first_fall_q, first_fall_d;
    logic       sclk_s, rise, fall;

    assign sclk_s     = sync2_q[0];
    assign cs_on      = ~sync2_q[2];
    assign rise       = cs_on & sclk_s & ~sclk_prev_q;
    assign fall       = cs_on & ~sclk_s & sclk_prev_q;
    assign miso       = miso_q;
    assign rx_byte    = rx_sr_q;
    assign byte_done  = byte_done_q;
    assign first_fall = first_fall_q;

    always_comb begin
        sync1_d      = {cs_n, mosi, sclk};
        sync2_d      = sync1_q;
        sclk_prev_d  = sclk_s;
        bit_cnt_d    = bit_cnt_q;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        miso_d       = miso_q;
        byte_done_d  = 1'b0;
        first_fall_d = 1'b0;
        if (!cs_on) begin
            bit_cnt_d = 3'd0;
            tx_sr_d   = 8'hFF;
            miso_d    = 1'b1;
        end else if (rise) begin
            rx_sr_d     = {rx_sr_q[6:0], sync2_q[1]};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
        end else if (fall) begin
            first_fall_d = (bit_cnt_q == 3'd1);
            // bit_cnt wrapped to 0: this fall closes the byte, start the next one
            if (bit_cnt_q == 3'd0) begin
                miso_d  = tx_byte[7];
                tx_sr_d = {tx_byte[6:0], 1'b1};
            end else begin
                miso_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= 3'b100;
            sync2_q      <= 3'b100;
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_sr_q      <= 8'hFF;
            tx_sr_q      <= 8'hFF;
            miso_q       <= 1'b1;
            byte_done_q  <= 1'b0;
            first_fall_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sclk_prev_q  <= sclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            miso_q       <= miso_d;
            byte_done_q  <= byte_done_d;
            first_fall_q <= first_fall_d;
        end
    end

endmodule

// File: rtl/sd_card_emu.sv
// SPI-mode SD card responder: command FSM and block read/write over a
// byte-wide synchronous RAM port.
module sd_card_emu
    import sd_pkg::*;
#(
    parameter int unsigned LBA_BITS   = 16,
    parameter int unsigned INIT_POLLS = 1,
    parameter int unsigned BUSY_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sdSCLK,
    input  logic                  sdMOSI,
    input  logic                  sdCS,
    output logic                  sdMISO,
    output logic [LBA_BITS+8:0]   mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  mem_wr,
    output logic [7:0]            mem_wdata,
    output logic                  active
);
    logic                byte_done, first_fall, cs_on;
    logic [7:0]          rx_byte, tx_byte;
    sd_state_e           state_q, state_d, nxt_q, nxt_d;
    logic [8:0]          cnt_q, cnt_d, off_q, off_d;
    logic [5:0]          idx_q, idx_d;
    logic [31:0]         arg_q, arg_d;
    logic [39:0]         resp_q, resp_d;
    logic                resp_long_q, resp_long_d;
    logic [LBA_BITS-1:0] lba_q, lba_d;
    logic [7:0]          data_q, data_d, poll_q, poll_d, mem_wdata_q, mem_wdata_d, r1;
    logic                rd_pend_q, rd_pend_d, idle_q, idle_d, app_q, app_d;
    logic                mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, active_q, active_d;
    logic [LBA_BITS+8:0] mem_addr_q, mem_addr_d;

    sd_spi_shifter u_shifter (
        .clk        (clk),
        .resetn     (resetn),
        .sclk       (sdSCLK),
        .mosi       (sdMOSI),
        .cs_n       (sdCS),
        .tx_byte    (tx_byte),
        .miso       (sdMISO),
        .rx_byte    (rx_byte),
        .byte_done  (byte_done),
        .first_fall (first_fall),
        .cs_on      (cs_on)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign active    = active_q;

    // state_q always names the byte currently on the wire, so this is the next byte out
    always_comb begin
        tx_byte = 8'hFF;
        case (state_q)
            ST_RESP:     tx_byte = resp_q[39:32];
            ST_RD_TOKEN: tx_byte = cnt_q[0] ? TOK_START : 8'hFF;
            ST_RD_DATA:  tx_byte = data_q;
            ST_WR_RESP:  tx_byte = TOK_DATA_OK;
            ST_WR_BUSY:  tx_byte = 8'h00;
            default:     tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        nxt_d       = nxt_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        resp_d      = resp_q;
        resp_long_d = resp_long_q;
        lba_d       = lba_q;
        idle_d      = idle_q;
        app_d       = app_q;
        poll_d      = poll_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        rd_pend_d   = mem_rd_q;
        data_d      = rd_pend_q ? mem_rdata : data_q;
        r1          = {7'd0, idle_q};

        // Prefetch the byte after the current one while the current one shifts out
        if (first_fall && ((state_q == ST_RD_TOKEN && cnt_q == 9'd1) ||
                           (state_q == ST_RD_DATA && cnt_q != 9'd511))) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = {lba_q, off_q};
            off_d      = off_q + 9'd1;
        end

        if (byte_done) begin
            case (state_q)
                ST_IDLE: if (rx_byte[7:6] == 2'b01) begin
                    state_d = ST_CMD;
                    idx_d   = rx_byte[5:0];
                    cnt_d   = 9'd1;
                end
                ST_CMD: if (cnt_q != 9'd5) begin
                    arg_d = {arg_q[23:0], rx_byte};
                    cnt_d = cnt_q + 9'd1;
                end else begin
                    state_d     = ST_NCR;
                    cnt_d       = 9'd0;
                    nxt_d       = ST_IDLE;
                    resp_long_d = 1'b0;
                    resp_d      = {r1, 32'd0};
                    app_d       = 1'b0;
                    case (idx_q)
                        CMD_GO_IDLE: begin
                            idle_d = 1'b1;
                            poll_d = 8'd0;
                            resp_d = {R1_IDLE, 32'd0};
                        end
                        CMD_SEND_IF: begin
                            resp_d      = {r1, 16'd0, 8'h01, arg_q[7:0]};
                            resp_long_d = 1'b1;
                        end
                        CMD_APP:      app_d = 1'b1;
                        CMD_SET_BLEN: ;
                        CMD_READ_OCR: begin
                            resp_d      = {r1, OCR_VAL};
                            resp_long_d = 1'b1;
                        end
                        ACMD_OP_COND: begin
                            if (!app_q)
                                resp_d = {r1 | R1_ILLEGAL, 32'd0};
                            else if (idle_q && (32'(poll_q) < INIT_POLLS))
                                poll_d = poll_q + 8'd1;
                            else begin
                                idle_d = 1'b0;
                                resp_d = 40'd0;
                            end
                        end
                        CMD_READ, CMD_WRITE: begin
                            if (idle_q || ((arg_q >> LBA_BITS) != 32'd0))
                                resp_d = {R1_PARAM | r1, 32'd0};
                            else begin
                                lba_d = arg_q[LBA_BITS-1:0];
                                off_d = 9'd0;
                                nxt_d = (idx_q == CMD_READ) ? ST_RD_TOKEN : ST_WR_TOKEN;
                            end
                        end
                        default: resp_d = {r1 | R1_ILLEGAL, 32'd0};
                    endcase
                end
                ST_NCR: begin
                    state_d = ST_RESP;
                    cnt_d   = 9'd0;
                end
                ST_RESP: if (cnt_q == (resp_long_q ? 9'd4 : 9'd0)) begin
                    state_d = nxt_q;
                    cnt_d   = 9'd0;
                end else begin
                    resp_d = {resp_q[31:0], 8'hFF};
                    cnt_d  = cnt_q + 9'd1;
                end
                ST_RD_TOKEN: begin
                    state_d = (cnt_q == 9'd1) ? ST_RD_DATA : ST_RD_TOKEN;
                    cnt_d   = (cnt_q == 9'd1) ? 9'd0 : cnt_q + 9'd1;
                end
                ST_RD_DATA: begin
                    state_d = (cnt_q == 9'd511) ? ST_RD_CRC : ST_RD_DATA;
                    cnt_d   = cnt_q + 9'd1;
                end
                ST_RD_CRC: begin
                    state_d = (cnt_q == 9'd1) ? ST_IDLE : ST_RD_CRC;
                    cnt_d   = (cnt_q == 9'd1) ? 9'd0 : cnt_q + 9'd1;
                end
                ST_WR_TOKEN: if (rx_byte == TOK_START) begin
                    state_d = ST_WR_DATA;
                    cnt_d   = 9'd0;
                end
                ST_WR_DATA: begin
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = {lba_q, off_q};
                    mem_wdata_d = rx_byte;
                    off_d       = off_q + 9'd1;
                    state_d     = (cnt_q == 9'd511) ? ST_WR_CRC : ST_WR_DATA;
                    cnt_d       = cnt_q + 9'd1;
                end
                ST_WR_CRC: begin
                    state_d = (cnt_q == 9'd1) ? ST_WR_RESP : ST_WR_CRC;
                    cnt_d   = (cnt_q == 9'd1) ? 9'd0 : cnt_q + 9'd1;
                end
                ST_WR_RESP: begin
                    if (BUSY_BYTES == 0) state_d = ST_IDLE;
                    else                 state_d = ST_WR_BUSY;
                    cnt_d = 9'd0;
                end
                ST_WR_BUSY: begin
                    state_d = (cnt_q == 9'(BUSY_BYTES - 1)) ? ST_IDLE : ST_WR_BUSY;
                    cnt_d   = cnt_q + 9'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (!cs_on) begin
            state_d = ST_IDLE;
            cnt_d   = 9'd0;
        end
        active_d = is_xfer(state_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            nxt_q       <= ST_IDLE;
            cnt_q       <= 9'd0;
            off_q       <= 9'd0;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            resp_q      <= 40'hFF_FFFF_FFFF;
            resp_long_q <= 1'b0;
            lba_q       <= '0;
            data_q      <= 8'hFF;
            rd_pend_q   <= 1'b0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
            poll_q      <= 8'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            resp_q      <= resp_d;
            resp_long_q <= resp_long_d;
            lba_q       <= lba_d;
            data_q      <= data_d;
            rd_pend_q   <= rd_pend_d;
            idle_q      <= idle_d;
            app_q       <= app_d;
            poll_q      <= poll_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: tb/tb_sd_card_emu.sv
// Bench for sd_card_emu: SPI master tasks, RAM model, MISO scoreboard queue.
module tb_sd_card_emu;
    localparam int LBA_BITS = 16;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                sdSCLK = 1'b0, sdMOSI = 1'b1, sdCS = 1'b1;
    logic                sdMISO, mem_rd, mem_wr, active;
    logic [LBA_BITS+8:0] mem_addr;
    logic [7:0]          mem_rdata = 8'h00;
    logic [7:0]          mem_wdata;

    logic [7:0] ram [0:8191];
    logic [7:0] exp_q [$];
    int total = 0, bad = 0;
    int wr_cnt = 0, overlap = 0;

    sd_card_emu #(.LBA_BITS(LBA_BITS), .INIT_POLLS(1), .BUSY_BYTES(4)) dut (
        .clk(clk), .resetn(resetn), .sdSCLK(sdSCLK), .sdMOSI(sdMOSI), .sdCS(sdCS),
        .sdMISO(sdMISO), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .active(active)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, block 3 preloaded with offset & 0xFF during reset
    always @(posedge clk) begin
        if (!resetn)
            for (int i = 0; i < 512; i++) ram[3*512 + i] <= 8'(i);
        if (mem_rd) mem_rdata <= ram[mem_addr[12:0]];
        if (mem_wr) ram[mem_addr[12:0]] <= mem_wdata;
        if (mem_rd && mem_wr) overlap <= overlap + 1;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            sdMOSI = tx[i];
            repeat (4) @(negedge clk);
            rx[i]  = sdMISO;
            sdSCLK = 1'b1;
            repeat (4) @(negedge clk);
            sdSCLK = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input string tag);
        logic [7:0] rx, e;
        spi_byte(tx, rx);
        if (exp_q.size() == 0) chk({tag, "_underflow"}, 40'(rx), 40'h1FF);
        else begin
            e = exp_q.pop_front();
            chk(tag, 40'(rx), 40'(e));
        end
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int n,
                          input logic [39:0] rsp, input string tag);
        logic [7:0] b [6];
        b[0] = {2'b01, idx};
        b[1] = arg[31:24]; b[2] = arg[23:16]; b[3] = arg[15:8]; b[4] = arg[7:0];
        b[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'hFF;
        for (int k = 0; k < 7; k++) exp_q.push_back(8'hFF);
        for (int k = 0; k < n; k++) exp_q.push_back(rsp[39-8*k -: 8]);
        for (int k = 0; k < 6; k++) xfer(b[k], tag);
        for (int k = 0; k < n + 1; k++) xfer(8'hFF, tag);
    endtask

    // Read stream after R1: gap FF, token FE, 512 data bytes, 2 CRC bytes
    task automatic rd_stream(input int n);
        for (int k = 0; k < n; k++) begin
            if (k == 0)       exp_q.push_back(8'hFF);
            else if (k == 1)  exp_q.push_back(8'hFE);
            else if (k < 514) exp_q.push_back(8'(k - 2));
            else              exp_q.push_back(8'hFF);
            xfer(8'hFF, "rd");
        end
    endtask

    initial begin
        int errs;
        repeat (4) @(negedge clk);
        chk("rst_miso", 40'(sdMISO), 40'd1);
        chk("rst_rd", 40'(mem_rd), 40'd0);
        chk("rst_wr", 40'(mem_wr), 40'd0);
        chk("rst_addr", 40'(mem_addr), 40'd0);
        chk("rst_wdata", 40'(mem_wdata), 40'd0);
        chk("rst_active", 40'(active), 40'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("miso_cs_high", 40'(sdMISO), 40'd1);
        sdCS = 1'b0;
        repeat (4) @(negedge clk);

        do_cmd(6'd0,  32'h0,     1, {8'h01, 32'h0},       "cmd0");
        do_cmd(6'd8,  32'h1AA,   5, 40'h01_00_00_01_AA,   "cmd8");
        do_cmd(6'd58, 32'h0,     5, 40'h01_C0_FF_80_00,   "cmd58_idle");
        do_cmd(6'd17, 32'h3,     1, {8'h41, 32'h0},       "cmd17_idle");
        do_cmd(6'd55, 32'h0,     1, {8'h01, 32'h0},       "cmd55_a");
        do_cmd(6'd41, 32'h0,     1, {8'h01, 32'h0},       "acmd41_a");
        do_cmd(6'd55, 32'h0,     1, {8'h01, 32'h0},       "cmd55_b");
        do_cmd(6'd41, 32'h0,     1, {8'h00, 32'h0},       "acmd41_b");
        do_cmd(6'd58, 32'h0,     5, 40'h00_C0_FF_80_00,   "cmd58_rdy");
        do_cmd(6'd16, 32'h200,   1, {8'h00, 32'h0},       "cmd16");
        do_cmd(6'd13, 32'h0,     1, {8'h04, 32'h0},       "cmd13_unk");

        // Aborted read: CS raised after 100 bytes following R1
        do_cmd(6'd17, 32'h3,     1, {8'h00, 32'h0},       "cmd17_abort");
        rd_stream(100);
        chk("active_mid_read", 40'(active), 40'd1);
        sdCS = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_miso", 40'(sdMISO), 40'd1);
        chk("abort_active", 40'(active), 40'd0);
        sdCS = 1'b0;
        repeat (4) @(negedge clk);

        do_cmd(6'd17, 32'h3,     1, {8'h00, 32'h0},       "cmd17");
        rd_stream(516);
        chk("rd_end_addr", 40'(mem_addr), 40'h7FF);
        chk("rd_end_active", 40'(active), 40'd0);

        do_cmd(6'd24, 32'h5,     1, {8'h00, 32'h0},       "cmd24");
        for (int k = 0; k < 2; k++) begin exp_q.push_back(8'hFF); xfer(8'hFF, "wr_wait"); end
        exp_q.push_back(8'hFF);
        xfer(8'hFE, "wr_token");
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(8'hFF);
            xfer(8'(i) ^ 8'h5A, "wr_data");
        end
        for (int k = 0; k < 2; k++) begin exp_q.push_back(8'hFF); xfer(8'hFF, "wr_crc"); end
        exp_q.push_back(8'h05);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        for (int k = 0; k < 6; k++) xfer(8'hFF, "wr_resp");
        repeat (4) @(negedge clk);
        errs = 0;
        for (int i = 0; i < 512; i++)
            if (ram[12'hA00 + 12'(i)] !== (8'(i) ^ 8'h5A)) errs++;
        chk("wr_ram_errs", 40'(errs), 40'd0);
        chk("wr_ram_first", 40'(ram[13'hA00]), 40'h5A);
        chk("wr_ram_last", 40'(ram[13'hBFF]), 40'hA5);
        chk("wr_end_addr", 40'(mem_addr), 40'hBFF);
        chk("wr_count", 40'(wr_cnt), 40'd512);

        do_cmd(6'd17, 32'h10000, 1, {8'h40, 32'h0},       "cmd17_oob");
        chk("oob_active", 40'(active), 40'd0);
        chk("rd_wr_overlap", 40'(overlap), 40'd0);
        chk("queue_drained", 40'(exp_q.size()), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_card_emu.md
# sd_card_emu

SPI-mode SD card responder: the target end of the link the RK8E controller drives as SPI master (sdSCLK/sdMOSI/sdCS in, sdMISO out). It decodes SD commands and serves 512-byte block reads and writes from a byte-wide synchronous RAM port, so the disk subsystem can run on-chip or in simulation without a physical card. Sits beside the PDP8e top level and is wired pin-for-pin to the RK8E SPI signals.

## Interface
- LBA_BITS, 16: implemented block-address bits; capacity is 2^LBA_BITS × 512 bytes.
- INIT_POLLS, 1: number of ACMD41 commands answered "still idle" before init completes.
- BUSY_BYTES, 4: 0x00 busy bytes sent after a write data response.
- clk  in  1  system clock (clk100), ≥8× sdSCLK.
- resetn  in  1  one clock; reset is asynchronous and active-low.
- sdSCLK  in  1  SPI clock from master, mode 0.
- sdMOSI  in  1  master-out data.
- sdCS  in  1  chip select, active low.
- sdMISO  out  1  target-out data.
- mem_addr  out  LBA_BITS+9  byte address {lba, offset[8:0]}.
- mem_rd  out  1  one-cycle read strobe; mem_rdata valid the next clk.
- mem_rdata  in  8  read data.
- mem_wr  out  1  one-cycle write strobe with mem_addr/mem_wdata.
- mem_wdata  out  8  write data.
- active  out  1  high while a read or write block transfer is in progress.

## Operation
- sdSCLK, sdMOSI, sdCS pass through 2-flop synchronizers. MOSI sampled on the synchronized SCLK rising edge; MISO updated on the falling edge. MSB first.
- sdCS high: MISO = 1, bit counter cleared, FSM → IDLE; any transfer aborted. Bytes already written stay written.
- States: IDLE → CMD (6 bytes; first byte must match 01xxxxxx, else ignored while MISO = 0xFF) → NCR (one 0xFF byte) → RESP (R1, plus 4 bytes for R3/R7) → one of IDLE, RD_TOKEN, WR_TOKEN.
- Card status: `idle` flag set by reset and CMD0, cleared when ACMD41 completes. CRC never checked.
- CMD0 → 0x01. CMD8 → R7 {R1, 0x00, 0x00, 0x01, arg[7:0]}. CMD55 → R1, arms app flag for next command only. ACMD41 → 0x01 for the first INIT_POLLS calls, then 0x00. CMD58 → R3 {R1, 0xC0FF8000} (CCS=1, block addressing). CMD16 → R1. Other/unknown → R1 | 0x04.
- CMD17/CMD24 while idle, or arg ≥ 2^LBA_BITS → R1 = 0x40|idle bit, no data phase.
- Read: R1 0x00, one 0xFF byte, token 0xFE, 512 data bytes from offset 0..511, CRC 0xFF 0xFF → IDLE.
- Write: R1 0x00, then ignore bytes until 0xFE; take 512 bytes, one mem_wr each; discard 2 CRC bytes; send 0x05, then BUSY_BYTES of 0x00 → IDLE (MISO 0xFF).
- Shifting out: next byte loaded into the TX shift register at byte boundary; idle output byte is 0xFF.

## Timing
- Reset values: sdMISO=1, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, active=0; idle flag=1, ACMD41 poll count=0.
- Byte-complete strobe fires 3 clk after the 8th rising SCLK edge (2 sync + 1 detect).
- Read prefetch: mem_rd issued the clk after the previous byte's first falling edge; data latched into the TX shift register before that byte's last falling edge. Needs SCLK ≤ clk/8.
- mem_wr issued the clk after each data byte completes; address = {lba, offset}, offset increments after each strobe, wraps 511 → 0 only at block end.
- mem_rd and mem_wr never asserted in the same clk.
- active rises with the token byte and falls after the last CRC or busy byte, or on CS deassert.
- Command bytes arriving during NCR/RESP/data phases are shifted in but ignored.

## Structure
- Package sd_pkg: command indices (0,8,16,17,24,41,55,58), tokens 0xFE / 0x05, R1 bit masks, OCR constant, FSM state encoding.
- Sub-module sd_spi_shifter: synchronizers, edge detect, RX/TX shift registers, byte strobe, TX load. The top holds the command FSM and memory port.

## Test plan
- Reset, CS low, CMD0 (40 00 00 00 00 95) → 0xFF NCR byte, then R1 0x01; MISO=1 while CS high.
- CMD8 arg 0x000001AA → 01 00 00 01 AA; CMD58 → 01 C0 FF 80 00.
- CMD55+ACMD41 twice → 0x01 then 0x00; CMD17 before init → 0x41.
- RAM preloaded with lba 3 = offset&0xFF; CMD17 arg 3 → 00, FF, FE, bytes 00..FF 00..FF, FF FF; mem_addr ends 0x7FF.
- CMD24 arg 5, FE + 512 bytes i^0x5A + 2 CRC → 05, four 00, RAM[0xA00+i] = i^0x5A.
- CS raised after 100 read bytes → MISO=1, active=0; next CMD17 completes normally. CMD17 arg 0x10000 → 0x40.
